cfg_chain_loader: RTL and testbench
===================================

# cfg_chain_loader

Word-to-serial configuration loader driving the head of the configuration shift chain (chain input `fpga_head`, output `fpga_tail`, clocked by `prog_clk`). Accepts configuration words over a valid/ready port, serializes them MSB-first into the chain, then verifies the load by recirculating the chain once and comparing CRCs of the driven and returned bit streams. Sits between the bitstream source (DMA/host bridge) and the chain; it gates chain shifting through `prog_clk_en`, which feeds the integration clock gate on the chain's `prog_clk`.

## Interface
- `WORD_W`, 32: configuration word width.
- `CHAIN_LEN`, 64: configuration bits in the chain, excluding the chain's output register; need not be a multiple of `WORD_W`.
- `prog_clk`  in  1  loader clock; the chain clock is `prog_clk` gated by `prog_clk_en`.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `cfg_data`  in  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  loader accepts a word this cycle.
- `fpga_head`  out  1  serial bit into the chain.
- `prog_clk_en`  out  1  chain shifts on the next `prog_clk` edge.
- `fpga_tail`  in  1  serial bit out of the chain (registered in the chain; not reset there).
- `busy`  out  1  LOAD or VERIFY in progress.
- `done`  out  1  one-cycle pulse at end of VERIFY.
- `pass`  out  1  last verify matched; valid from `done` until the next accepted `start`.
- `load_crc`  out  16  CRC of the last loaded bit stream.

## Operation
- States: IDLE, LOAD, VERIFY. Reset → IDLE; all outputs 0; `load_crc` = 0.
- IDLE: `start`=1 → LOAD. Clears the bit counter and both CRCs (to 0xFFFF) and clears `pass`. `start` is ignored in LOAD and VERIFY.
- LOAD:
  - Word buffer of WORD_W bits plus a remaining-bit count.
  - `cfg_ready`=1 when the buffer is empty, or holds 1 bit whose shift completes this cycle, and fewer than CHAIN_LEN bits have been accepted. Streaming is therefore bubble-free.
  - `fpga_head` = buffer MSB (combinational).
  - `prog_clk_en` = 1 exactly when the buffer holds a bit.
  - Each enabled cycle: shift the buffer left, increment the bit counter, and update the load CRC with `fpga_head`.
  - The final word contributes only its top (CHAIN_LEN mod WORD_W, or WORD_W if 0) bits; its remaining low-order bits are discarded.
  - Starvation (`cfg_valid`=0, buffer empty): `prog_clk_en`=0 and the chain holds.
  - Counter reaches CHAIN_LEN → VERIFY on the next cycle.
- VERIFY:
  - Lasts exactly CHAIN_LEN+1 cycles with `prog_clk_en`=1 and `fpga_head` = `fpga_tail` (combinational recirculation). The chain plus its output register form a CHAIN_LEN+1 ring, so the contents are restored at the end.
  - The first returned bit is the stale output register and is ignored.
  - Returned bits 2..CHAIN_LEN+1 (the loaded bits in push order) update the readback CRC.
  - After the last cycle: go to IDLE; `done`=1 for one cycle; `pass` = (readback CRC == load CRC); `load_crc` latched.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, serial MSB-first, no reflection, no final XOR.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Chain contents are undefined; a new `start` reloads fully.

## Timing
- Word accepted at edge E: its first bit is on `fpga_head` with `prog_clk_en`=1 during cycle E..E+1. The chain captures it at E+1.
- A word takes WORD_W enabled cycles. The next word may be accepted at the edge that consumes the last bit.
- LOAD → VERIFY transition adds no idle cycle.
- Total with no starvation: 1 (start) + CHAIN_LEN + (CHAIN_LEN+1) cycles, then `done`.
- `cfg_ready` is never asserted outside LOAD. `cfg_valid` outside LOAD is ignored.

## Test plan
- Default parameters, words 0xDEADBEEF then 0x12345678, cycle-accurate chain model: `done` after 1+64+65 cycles; `pass`=1; `load_crc` matches the reference CRC of the 64 bits; chain bit 63 = 1 (first bit) and chain holds 0xDEADBEEF12345678 after VERIFY.
- Same data with `cfg_valid` dropped for 7 cycles mid-word-2: `prog_clk_en`=0 for exactly those cycles; chain contents unchanged; `pass`=1.
- Chain model flips one bit in flight during VERIFY: `pass`=0, `done` pulses once.
- `reset` asserted in the 20th LOAD cycle: all outputs 0 immediately. A new `start` with the same words gives `pass`=1.
- `start` pulsed during LOAD and during VERIFY: no effect on timing or result.
- CHAIN_LEN=40: exactly 2 words accepted (third `cfg_valid` sees `cfg_ready`=0). The low 24 bits of word 2 do not reach the chain. `pass`=1.

Source files
------------

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
//
// Word-to-serial configuration loader for the head of the configuration
// shift chain. Words arrive over a valid/ready port and are shifted into the
// chain MSB-first. The chain is then rotated once through its output register
// so the load can be checked. The check compares the CRC-16-CCITT of the
// driven bit stream with the CRC of the returned bit stream. Chain shifting is
// gated through prog_clk_en, which feeds the integration clock gate.
//
// Parameters
//   WORD_W     configuration word width
//   CHAIN_LEN  configuration bits in the chain (excluding its output register)
//
// Ports
//   prog_clk     in   loader clock (chain clock = prog_clk gated by prog_clk_en)
//   reset        in   asynchronous, active-low reset
//   start        in   single-cycle load request, sampled only in IDLE
//   cfg_data     in   configuration word, bit WORD_W-1 shifted first
//   cfg_valid    in   cfg_data valid
//   cfg_ready    out  loader accepts a word this cycle
//   fpga_head    out  serial bit into the chain
//   prog_clk_en  out  chain shifts on the next prog_clk edge
//   fpga_tail    in   serial bit out of the chain (registered in the chain)
//   busy         out  LOAD or VERIFY in progress
//   done         out  one-cycle pulse at the end of VERIFY
//   pass         out  last verify matched; valid from done until next start
//   load_crc     out  CRC of the last loaded bit stream

module cfg_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              fpga_head,
    output logic              prog_clk_en,
    input  logic              fpga_tail,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       load_crc
);

    // Counter width must hold both CHAIN_LEN and WORD_W.
    localparam int MAX_V = (CHAIN_LEN > WORD_W) ? CHAIN_LEN : WORD_W;
    localparam int CW    = $clog2(MAX_V + 2);
    localparam int BW    = $clog2(WORD_W + 1);

    localparam logic [CW-1:0] CHAIN_LEN_C = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] LAST_BIT_C  = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] WORD_W_C    = CW'(WORD_W);
    localparam logic [BW-1:0] ONE_B       = BW'(1);
    localparam logic [CW-1:0] ONE_C       = CW'(1);
    localparam logic [15:0]   CRC_POLY    = 16'h1021;
    localparam logic [15:0]   CRC_INIT    = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [WORD_W-1:0] buf_q;
    logic [BW-1:0]     buf_cnt_q;
    logic [CW-1:0]     acc_cnt_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [15:0]       load_crc_run_q;
    logic [15:0]       rb_crc_q;
    logic              pass_q;
    logic              done_q;
    logic [15:0]       load_crc_q;

    logic              buf_has_bit;
    logic              accept;
    logic [CW-1:0]     remaining;
    logic [CW-1:0]     take_bits;
    logic [15:0]       rb_crc_next;

    // Serial CRC-16-CCITT step, MSB-first, no reflection.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and chain-side outputs.
    // cfg_ready is also raised when the buffer holds its final bit, because
    // that bit leaves on this edge. This lets the next word land without a
    // bubble. The LOAD exit is taken on the edge that shifts the last chain
    // bit, so VERIFY starts immediately.
    always_comb begin
        state_d     = state_q;
        cfg_ready   = 1'b0;
        fpga_head   = 1'b0;
        prog_clk_en = 1'b0;
        buf_has_bit = (buf_cnt_q != '0);
        remaining   = CHAIN_LEN_C - acc_cnt_q;
        take_bits   = (remaining > WORD_W_C) ? WORD_W_C : remaining;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfg_ready   = ((buf_cnt_q == '0) || (buf_cnt_q == ONE_B)) &&
                              (acc_cnt_q < CHAIN_LEN_C);
                fpga_head   = buf_q[WORD_W-1];
                prog_clk_en = buf_has_bit;
                if (buf_has_bit && (bit_cnt_q == LAST_BIT_C)) begin
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                prog_clk_en = 1'b1;
                fpga_head   = fpga_tail;
                if (bit_cnt_q == CHAIN_LEN_C) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign accept = cfg_ready & cfg_valid;

    // The first returned bit is the stale output register of the chain.
    // It is therefore excluded from the readback CRC.
    always_comb begin
        rb_crc_next = rb_crc_q;
        if (bit_cnt_q != '0) begin
            rb_crc_next = crc_step(rb_crc_q, fpga_tail);
        end
    end

    // Datapath: word buffer, bit counters and CRCs.
    // The final word is loaded whole, but its count is clipped to the bits the
    // chain still needs. Its low-order bits are therefore never shifted out.
    // bit_cnt is reused as the VERIFY cycle counter: it wraps to 0 on the LOAD
    // exit edge.
    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            buf_q          <= '0;
            buf_cnt_q      <= '0;
            acc_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            load_crc_run_q <= '0;
            rb_crc_q       <= '0;
            pass_q         <= 1'b0;
            done_q         <= 1'b0;
            load_crc_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        buf_q          <= '0;
                        buf_cnt_q      <= '0;
                        acc_cnt_q      <= '0;
                        bit_cnt_q      <= '0;
                        load_crc_run_q <= CRC_INIT;
                        rb_crc_q       <= CRC_INIT;
                        pass_q         <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        buf_q     <= cfg_data;
                        buf_cnt_q <= BW'(take_bits);
                        acc_cnt_q <= acc_cnt_q + take_bits;
                    end else if (buf_has_bit) begin
                        buf_q     <= buf_q << 1;
                        buf_cnt_q <= buf_cnt_q - ONE_B;
                    end
                    if (buf_has_bit) begin
                        bit_cnt_q      <= (bit_cnt_q == LAST_BIT_C) ? '0 : bit_cnt_q + ONE_C;
                        load_crc_run_q <= crc_step(load_crc_run_q, buf_q[WORD_W-1]);
                    end
                end
                ST_VERIFY: begin
                    bit_cnt_q <= bit_cnt_q + ONE_C;
                    rb_crc_q  <= rb_crc_next;
                    if (bit_cnt_q == CHAIN_LEN_C) begin
                        done_q     <= 1'b1;
                        pass_q     <= (rb_crc_next == load_crc_run_q);
                        load_crc_q <= load_crc_run_q;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign pass     = pass_q;
    assign load_crc = load_crc_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader
//
// Testbench for cfg_chain_loader. It drives two instances: the default
// 64-bit chain and a 40-bit chain. Each instance has its own cycle-accurate
// chain model (shift register plus unreset output register). Expected results
// are queued when a load is launched and compared when done pulses.

module tb_cfg_chain_loader;

    localparam int WORD_W = 32;
    localparam int LEN_A  = 64;
    localparam int LEN_B  = 40;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic              reset;
    logic              sel_b;
    logic              start;
    logic              cfg_valid;
    logic [WORD_W-1:0] cfg_data;
    logic              flip;

    logic        start_a, cfg_valid_a, cfg_ready_a, fpga_head_a, prog_clk_en_a, fpga_tail_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] load_crc_a;
    logic        start_b, cfg_valid_b, cfg_ready_b, fpga_head_b, prog_clk_en_b, fpga_tail_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] load_crc_b;

    logic [LEN_A-1:0] chain_a    = '0;
    logic             tail_reg_a = 1'b0;
    logic [LEN_B-1:0] chain_b    = '0;
    logic             tail_reg_b = 1'b0;

    assign start_a     = start & ~sel_b;
    assign cfg_valid_a = cfg_valid & ~sel_b;
    assign fpga_tail_a = tail_reg_a ^ (flip & ~sel_b);
    assign start_b     = start & sel_b;
    assign cfg_valid_b = cfg_valid & sel_b;
    assign fpga_tail_b = tail_reg_b ^ (flip & sel_b);

    cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_A)) dut_a (
        .prog_clk    (prog_clk),
        .reset       (reset),
        .start       (start_a),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid_a),
        .cfg_ready   (cfg_ready_a),
        .fpga_head   (fpga_head_a),
        .prog_clk_en (prog_clk_en_a),
        .fpga_tail   (fpga_tail_a),
        .busy        (busy_a),
        .done        (done_a),
        .pass        (pass_a),
        .load_crc    (load_crc_a)
    );

    cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(LEN_B)) dut_b (
        .prog_clk    (prog_clk),
        .reset       (reset),
        .start       (start_b),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid_b),
        .cfg_ready   (cfg_ready_b),
        .fpga_head   (fpga_head_b),
        .prog_clk_en (prog_clk_en_b),
        .fpga_tail   (fpga_tail_b),
        .busy        (busy_b),
        .done        (done_b),
        .pass        (pass_b),
        .load_crc    (load_crc_b)
    );

    // Chain models: bit 0 receives the head, the top bit feeds the output register.
    always @(posedge prog_clk) begin
        if (prog_clk_en_a) begin
            chain_a    <= {chain_a[LEN_A-2:0], fpga_head_a};
            tail_reg_a <= chain_a[LEN_A-1];
        end
        if (prog_clk_en_b) begin
            chain_b    <= {chain_b[LEN_B-2:0], fpga_head_b};
            tail_reg_b <= chain_b[LEN_B-1];
        end
    end

    logic        ready_m, en_m, head_m, busy_m, done_m, pass_m;
    logic [15:0] crc_m;
    logic [63:0] chain_m;

    assign ready_m = sel_b ? cfg_ready_b   : cfg_ready_a;
    assign en_m    = sel_b ? prog_clk_en_b : prog_clk_en_a;
    assign head_m  = sel_b ? fpga_head_b   : fpga_head_a;
    assign busy_m  = sel_b ? busy_b        : busy_a;
    assign done_m  = sel_b ? done_b        : done_a;
    assign pass_m  = sel_b ? pass_b        : pass_a;
    assign crc_m   = sel_b ? load_crc_b    : load_crc_a;
    assign chain_m = sel_b ? {24'h0, chain_b} : chain_a;

    typedef struct {
        logic        pass;
        logic [15:0] crc;
        logic [63:0] chain;
        int          latency;
        int          zero_en;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference CRC-16-CCITT over the top len bits of stream, MSB first.
    function automatic logic [15:0] refCrc(input logic [63:0] stream, input int len);
        logic [15:0] c;
        logic        b;
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            b = stream[63-i];
            if (c[15] ^ b) c = {c[14:0], 1'b0} ^ 16'h1021;
            else           c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Runs one load on the selected instance.
    // stall_len: cfg_valid is held low for that many cycles when word 2 is first wanted.
    // flip_at: VERIFY cycle whose returned bit is inverted (-1 = none).
    // poke_start: pulse start during LOAD and during VERIFY.
    // abort_at: LOAD cycle in which reset is asserted (0 = none).
    task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                 input int n_words, input int stall_len, input int flip_at,
                                 input bit poke_start, input int abort_at);
        logic [31:0] words [3];
        logic [63:0] snap;
        exp_t        e;
        int          len, cyc, idx, stall_left, zero_en, en_cnt, late_ready;
        bit          got, stall_begun, fire, snap_taken, snap_checked;

        words = '{w0, w1, w2};
        len   = sel_b ? LEN_B : LEN_A;
        if (abort_at == 0) begin
            e.pass    = (flip_at < 0);
            e.chain   = {w0, w1} >> (64 - len);
            if (flip_at > 0) e.chain = e.chain ^ (64'd1 << (len - flip_at));
            e.crc     = refCrc({w0, w1}, len);
            e.latency = 1 + len + len + 1 + stall_len;
            e.zero_en = 1 + stall_len;
            sb_q.push_back(e);
        end

        idx = 0; stall_left = 0; zero_en = 0; en_cnt = 0; late_ready = 0;
        got = 0; stall_begun = 0; snap_taken = 0; snap_checked = 0; snap = '0;

        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        cyc = 1;
        while (!got && cyc < 400) begin
            @(negedge prog_clk);
            if (done_m) begin
                got = 1;
            end else if (abort_at > 0 && cyc == abort_at) begin
                reset = 1'b0;
                #1;
                checkOutput("abort_outputs_zero",
                            64'({busy_m, done_m, pass_m, ready_m, en_m, head_m, crc_m}), 64'd0);
                start = 1'b0; cfg_valid = 1'b0; flip = 1'b0;
                @(negedge prog_clk);
                reset = 1'b1;
                return;
            end else begin
                start = poke_start && (cyc == 30 || cyc == 100);
                flip  = (flip_at >= 0) && (en_cnt == len + flip_at);
                if (idx == 1 && stall_len > 0 && !stall_begun && ready_m) begin
                    stall_begun = 1;
                    stall_left  = stall_len;
                end
                if (stall_begun && !snap_taken && stall_left == stall_len - 1) begin
                    snap       = chain_m;
                    snap_taken = 1;
                end
                if (snap_taken && !snap_checked && stall_left == 0) begin
                    checkOutput("chain_hold_in_stall", chain_m, snap);
                    snap_checked = 1;
                end
                cfg_valid = (idx < n_words) && (stall_left == 0);
                cfg_data  = cfg_valid ? words[idx] : '0;
                fire      = cfg_valid && ready_m;
                if (!en_m && busy_m) zero_en++;
                if (ready_m && idx >= 2) late_ready++;
                if (en_m) en_cnt++;
                @(posedge prog_clk);
                if (fire) idx++;
                if (stall_left > 0) stall_left--;
                cyc++;
            end
        end
        start = 1'b0; cfg_valid = 1'b0; flip = 1'b0;

        if (!got) begin
            checkOutput("done_timeout", 64'(got), 64'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            checkOutput("pass",          64'(pass_m),      64'(e.pass));
            checkOutput("load_crc",      64'(crc_m),       64'(e.crc));
            checkOutput("done_latency",  64'(cyc - 1),     64'(e.latency));
            checkOutput("en_low_cycles", 64'(zero_en),     64'(e.zero_en));
            checkOutput("words_taken",   64'(idx),         64'd2);
            checkOutput("ready_when_full", 64'(late_ready), 64'd0);
            checkOutput("idle_at_done",  64'({busy_m, ready_m, en_m}), 64'd0);
            checkOutput("chain_content", chain_m,          e.chain);
            if (stall_len > 0) checkOutput("stall_snap_done", 64'(snap_checked), 64'd1);
            @(negedge prog_clk);
            checkOutput("done_one_pulse", 64'(done_m), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b0; sel_b = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; flip = 1'b0;
        repeat (3) @(negedge prog_clk);
        checkOutput("reset_state_a",
                    64'({busy_a, done_a, pass_a, cfg_ready_a, prog_clk_en_a, fpga_head_a, load_crc_a}), 64'd0);
        checkOutput("reset_state_b",
                    64'({busy_b, done_b, pass_b, cfg_ready_b, prog_clk_en_b, fpga_head_b, load_crc_b}), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge prog_clk);

        $display("[TB] plain load, 64-bit chain");
        applyStimulus(32'hDEADBEEF, 32'h12345678, 32'h0, 2, 0, -1, 0, 0);
        $display("[TB] starved for 7 cycles before word 2");
        applyStimulus(32'hDEADBEEF, 32'h12345678, 32'h0, 2, 7, -1, 0, 0);
        $display("[TB] returned bit corrupted during verify");
        applyStimulus(32'hDEADBEEF, 32'h12345678, 32'h0, 2, 0, 10, 0, 0);
        $display("[TB] reset in LOAD cycle 20, then reload");
        applyStimulus(32'hDEADBEEF, 32'h12345678, 32'h0, 2, 0, -1, 0, 20);
        applyStimulus(32'hDEADBEEF, 32'h12345678, 32'h0, 2, 0, -1, 0, 0);
        $display("[TB] start pulsed during LOAD and VERIFY");
        applyStimulus(32'hA5A5F00F, 32'h0123BEEF, 32'h0, 2, 0, -1, 1, 0);

        $display("[TB] 40-bit chain, third word must be refused");
        repeat (2) @(negedge prog_clk);
        sel_b = 1'b1;
        applyStimulus(32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 3, 0, -1, 0, 0);

        repeat (2) @(negedge prog_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
